// File: rtl/serial_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_shifter_if
// Brief    : Request/response handshake bundle for the serial shifter.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_shifter_if #(
    parameter int N = 16,
    parameter int C = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [C-1:0] in_cnt;
    logic [1:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_shifter.sv
`default_nettype none
// ============================================================================
// Module   : serial_shifter
// Brief    : Multi-cycle shifter/rotator moving one bit position per clock.
// Revision : 1.0 - initial release
// ============================================================================
module serial_shifter #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    serial_shifter_if.slave  bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_OP_ROR = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_SRA = 2'b10;
    localparam logic [1:0] c_OP_SRL = 2'b11;

    logic [1:0]   r_state;
    logic [N-1:0] r_data;
    logic [C-1:0] r_cnt;
    logic [1:0]   r_op;
    logic [N-1:0] w_step;

    // Single-bit step; rotate goes right so it undoes the ALU's rotate-left.
    always_comb begin
        w_step = r_data;
        case (r_op)
            c_OP_ROR: w_step = {r_data[0], r_data[N-1:1]};
            c_OP_SLL: w_step = {r_data[N-2:0], 1'b0};
            c_OP_SRA: w_step = {r_data[N-1], r_data[N-1:1]};
            c_OP_SRL: w_step = {1'b0, r_data[N-1:1]};
            default:  w_step = r_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_data  <= bus.in_data;
                        r_cnt   <= bus.in_cnt;
                        r_op    <= bus.in_op;
                        r_state <= (bus.in_cnt == '0) ? c_DONE : c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == C'(1)) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // All handshake outputs decode directly from the state register.
    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.out_data  = r_data;
endmodule
`default_nettype wire
